// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame controller.
//   tx_state_e : frame FSM state codes
//   START_BIT, STOP_BIT, IDLE_LEVEL : serial line levels
package uart_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_baud_tick.sv
// Bit-time prescaler for the UART transmitter.
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   clear_i     : restart the bit-time (asserted on every FSM state change)
//   bit_start_o : high in the first cycle of a bit-time
//   bit_end_o   : high in the last cycle of a bit-time (1-cycle pulse)
module uart_tx_baud_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic bit_start_o,
    output logic bit_end_o
);

    localparam int              CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] TC   = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end_o   = (cnt_q == TC);
    assign bit_start_o = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (clear_i || bit_end_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller / serializer.
// Accepts a parallel word when idle and shifts it out LSB first framed as
// start bit, data bits, optional parity bit, stop bit.
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   P_Data     : parallel data, sampled on accept
//   data_valid : word-present strobe (also drives the external parity stage)
//   par_en     : 1 = append parity bit, sampled on accept
//   par_bit    : registered parity from the parity stage, valid 1 clk after data_valid
//   TX_OUT     : registered serial line, idle high
//   busy       : registered, high while a frame is on the line
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int               IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  par_en_q, par_en_d;
    logic                  par_q, par_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  bit_start;
    logic                  bit_end;

    uart_tx_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (state_d != state_q),
        .bit_start_o (bit_start),
        .bit_end_o   (bit_end)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_valid) state_d = START;
            START:   if (bit_end) state_d = DATA;
            DATA:    if (bit_end && (idx_q == IDX_LAST)) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (bit_end) state_d = STOP;
            STOP:    if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: shift register, bit index, latched frame options
    always_comb begin
        shift_d  = shift_q;
        idx_d    = idx_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        if ((state_q == IDLE) && data_valid) begin
            shift_d  = P_Data;
            par_en_d = par_en;
        end
        // The parity stage registers on the accept edge, so its result is
        // valid during the first START cycle. Capturing it here keeps the
        // frame immune to later data_valid strobes that re-evaluate it.
        if ((state_q == START) && bit_start) begin
            par_d = par_bit;
        end
        if ((state_q == DATA) && bit_end) begin
            shift_d = shift_q >> 1;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Output logic: decoded from the state being entered so the registered
    // outputs change on the same edge as the state.
    always_comb begin
        tx_d   = IDLE_LEVEL;
        busy_d = 1'b1;
        case (state_d)
            IDLE: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
            end
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            STOP:    tx_d = STOP_BIT;
            default: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q  <= '0;
            idx_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            tx_q     <= IDLE_LEVEL;
            busy_q   <= 1'b0;
        end else begin
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign TX_OUT = tx_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed testbench for uart_tx_frame_ctrl: one instance at 1 clk/bit,
// one at 4 clk/bit, each fed by a small registered parity-stage model.
module tb_uart_tx_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [7:0] pd1 = '0, pd4 = '0;
    logic       dv1 = 1'b0, dv4 = 1'b0;
    logic       pe1 = 1'b0, pe4 = 1'b0;
    logic       odd1 = 1'b0, odd4 = 1'b0;
    logic       pb1, pb4;
    logic       tx1, tx4, busy1, busy4;

    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    // Parity stage models: registered, re-evaluated on every data_valid
    always @(posedge clk or posedge rst) begin
        if (rst) pb1 <= 1'b0;
        else if (dv1) pb1 <= odd1 ? ~^pd1 : ^pd1;
    end
    always @(posedge clk or posedge rst) begin
        if (rst) pb4 <= 1'b0;
        else if (dv4) pb4 <= odd4 ? ~^pd4 : ^pd4;
    end

    uart_tx_frame_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .P_Data(pd1), .data_valid(dv1),
        .par_en(pe1), .par_bit(pb1), .TX_OUT(tx1), .busy(busy1)
    );

    uart_tx_frame_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut4 (
        .clk(clk), .rst(rst), .P_Data(pd4), .data_valid(dv4),
        .par_en(pe4), .par_bit(pb4), .TX_OUT(tx4), .busy(busy4)
    );

    task automatic test_reset();
        @(negedge clk);
        check_cnt++; if ({tx1, busy1} !== 2'b10) $display("FAIL reset_dut1 tx/busy=%b required 10", {tx1, busy1}); else pass_cnt++;
        check_cnt++; if ({tx4, busy4} !== 2'b10) $display("FAIL reset_dut4 tx/busy=%b required 10", {tx4, busy4}); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        check_cnt++; if ({tx1, busy1} !== 2'b10) $display("FAIL idle_dut1 tx/busy=%b required 10", {tx1, busy1}); else pass_cnt++;
        $display("test_reset done: checks=%0d", check_cnt);
    endtask

    // T1: 0xA5, parity on, even parity
    task automatic test_parity_frame();
        logic [0:10] exp_tx = 11'b01010010101;
        odd1 = 1'b0; pd1 = 8'hA5; pe1 = 1'b1; dv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv1 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            check_cnt++; if (tx1 !== exp_tx[k]) $display("FAIL t1_tx cycle %0d got %b required %b", k, tx1, exp_tx[k]); else pass_cnt++;
            check_cnt++; if (busy1 !== 1'b1) $display("FAIL t1_busy cycle %0d got %b required 1", k, busy1); else pass_cnt++;
            @(negedge clk);
        end
        check_cnt++; if ({tx1, busy1} !== 2'b10) $display("FAIL t1_end tx/busy=%b required 10", {tx1, busy1}); else pass_cnt++;
        $display("test_parity_frame 0xA5 done: checks=%0d", check_cnt);
    endtask

    // T2: 0x3C, parity off -> 10-cycle frame
    task automatic test_no_parity();
        logic [0:9] exp_tx = 10'b0001111001;
        pd1 = 8'h3C; pe1 = 1'b0; dv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv1 = 1'b0; pe1 = 1'b1;  // mid-frame change must have no effect
        for (int k = 0; k < 10; k++) begin
            check_cnt++; if (tx1 !== exp_tx[k]) $display("FAIL t2_tx cycle %0d got %b required %b", k, tx1, exp_tx[k]); else pass_cnt++;
            check_cnt++; if (busy1 !== 1'b1) $display("FAIL t2_busy cycle %0d got %b required 1", k, busy1); else pass_cnt++;
            @(negedge clk);
        end
        check_cnt++; if ({tx1, busy1} !== 2'b10) $display("FAIL t2_end tx/busy=%b required 10", {tx1, busy1}); else pass_cnt++;
        pe1 = 1'b0;
        $display("test_no_parity 0x3C done: checks=%0d", check_cnt);
    endtask

    // T3: 0x01 odd parity (bit 0); 0x03 strobed mid-DATA is dropped and must
    // not disturb the latched parity
    task automatic test_drop_midframe();
        logic [0:10] exp_tx = 11'b01000000001;
        odd1 = 1'b1; pd1 = 8'h01; pe1 = 1'b1; dv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv1 = 1'b0;
        for (int k = 0; k < 11; k++) begin
            check_cnt++; if (tx1 !== exp_tx[k]) $display("FAIL t3_tx cycle %0d got %b required %b", k, tx1, exp_tx[k]); else pass_cnt++;
            if (k == 4) begin pd1 = 8'h03; dv1 = 1'b1; end
            else dv1 = 1'b0;
            @(negedge clk);
        end
        for (int k = 0; k < 12; k++) begin
            check_cnt++; if ({tx1, busy1} !== 2'b10) $display("FAIL t3_dropped cycle %0d tx/busy=%b required 10", k, {tx1, busy1}); else pass_cnt++;
            @(negedge clk);
        end
        odd1 = 1'b0;
        $display("test_drop_midframe done: checks=%0d", check_cnt);
    endtask

    // T4: 4 clk per bit, 0xFF with even parity (0) -> 44 busy cycles
    task automatic test_slow_bits();
        logic exp_b;
        int   b;
        pd4 = 8'hFF; pe4 = 1'b1; dv4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv4 = 1'b0;
        for (int k = 0; k < 44; k++) begin
            b = k / 4;
            exp_b = (b == 0 || b == 9) ? 1'b0 : 1'b1;
            check_cnt++; if (tx4 !== exp_b) $display("FAIL t4_tx cycle %0d got %b required %b", k, tx4, exp_b); else pass_cnt++;
            check_cnt++; if (busy4 !== 1'b1) $display("FAIL t4_busy cycle %0d got %b required 1", k, busy4); else pass_cnt++;
            @(negedge clk);
        end
        check_cnt++; if ({tx4, busy4} !== 2'b10) $display("FAIL t4_end tx/busy=%b required 10", {tx4, busy4}); else pass_cnt++;
        $display("test_slow_bits 0xFF done: checks=%0d", check_cnt);
    endtask

    // T5: reset at DATA bit 3 aborts at once; then a clean 0x55 frame
    task automatic test_reset_midframe();
        logic [0:9] exp_tx = 10'b0101010101;
        pd1 = 8'hC3; pe1 = 1'b1; dv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv1 = 1'b0;
        repeat (4) @(negedge clk);
        check_cnt++; if ({tx1, busy1} !== 2'b01) $display("FAIL t5_bit3 tx/busy=%b required 01", {tx1, busy1}); else pass_cnt++;
        #1 rst = 1'b1;
        #1;
        check_cnt++; if ({tx1, busy1} !== 2'b10) $display("FAIL t5_abort tx/busy=%b required 10", {tx1, busy1}); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        pd1 = 8'h55; pe1 = 1'b0; dv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dv1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check_cnt++; if (tx1 !== exp_tx[k]) $display("FAIL t5_tx cycle %0d got %b required %b", k, tx1, exp_tx[k]); else pass_cnt++;
            check_cnt++; if (busy1 !== 1'b1) $display("FAIL t5_busy cycle %0d got %b required 1", k, busy1); else pass_cnt++;
            @(negedge clk);
        end
        check_cnt++; if ({tx1, busy1} !== 2'b10) $display("FAIL t5_end tx/busy=%b required 10", {tx1, busy1}); else pass_cnt++;
        $display("test_reset_midframe done: checks=%0d", check_cnt);
    endtask

    // T6: data_valid held high, 0x11 then 0x22 with one idle clk between
    task automatic test_back_to_back();
        logic [0:20] exp_tx   = 21'b010001000110010001001;
        logic [0:20] exp_busy = 21'b111111111101111111111;
        pd1 = 8'h11; pe1 = 1'b0; dv1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pd1 = 8'h22;
        for (int k = 0; k < 21; k++) begin
            check_cnt++; if (tx1 !== exp_tx[k]) $display("FAIL t6_tx cycle %0d got %b required %b", k, tx1, exp_tx[k]); else pass_cnt++;
            check_cnt++; if (busy1 !== exp_busy[k]) $display("FAIL t6_busy cycle %0d got %b required %b", k, busy1, exp_busy[k]); else pass_cnt++;
            if (k == 11) dv1 = 1'b0;
            @(negedge clk);
        end
        check_cnt++; if ({tx1, busy1} !== 2'b10) $display("FAIL t6_end tx/busy=%b required 10", {tx1, busy1}); else pass_cnt++;
        $display("test_back_to_back done: checks=%0d", check_cnt);
    endtask

    initial begin
        test_reset();
        test_parity_frame();
        test_no_parity();
        test_drop_midframe();
        test_slow_bits();
        test_reset_midframe();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
